// File: rtl/pkt_meta_merge_out_pkg.sv
// Shared beat/metadata field definitions for the egress merge stage.
package pkt_meta_merge_out_pkg;

  localparam int BEAT_W = 134;
  localparam int TAG_HI = 133;
  localparam int TAG_LO = 132;

  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  localparam int MAC_W   = 48;
  localparam int DMAC_HI = 127;
  localparam int DMAC_LO = 80;
  localparam int SMAC_HI = 79;
  localparam int SMAC_LO = 32;

  localparam int DMAC_LSB    = 0;
  localparam int REWRITE_BIT = 63;
  localparam int DROP_BIT    = 64;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP} state_t;

  // Tag bit 1 marks the last beat (tail or single), bit 0 the first (head or single).
  function automatic logic tag_is_last(input logic [1:0] tag);
    return tag[1];
  endfunction

  function automatic logic tag_is_first(input logic [1:0] tag);
    return tag[0];
  endfunction

endpackage

// File: rtl/pkt_meta_merge_out_fifo.sv
// hypipe_sync_fifo: single-clock FIFO with registered read, head peek and occupancy count.
module hypipe_sync_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  output logic [W-1:0]        rd_data,
  output logic [W-1:0]        peek_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                do_wr, do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign peek_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pkt_meta_merge_out.sv
// Egress merge: pairs buffered packets with metadata in order, rewrites dst MAC or drops.
// Optional REPLACE_SRC_MAC_EN: rewritten heads also get src MAC = original dst MAC.
module pkt_meta_merge_out
  import pkt_meta_merge_out_pkg::*;
#(
  parameter int PKT_DEPTH_LOG2  = 9,
  parameter int META_DEPTH_LOG2 = 4,
  parameter int META_W          = 128,
  parameter int PKT_MAX_BEATS   = 128
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pkt_valid,
  input  logic [BEAT_W-1:0] i_pkt,
  input  logic              i_meta_valid,
  input  logic [META_W-1:0] i_meta,
  output logic              o_data_valid,
  output logic [BEAT_W-1:0] o_data,
  output logic [15:0]       o_pkt_drop_cnt,
  output logic              o_meta_ovf
);

  localparam int PW = PKT_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PKT_DEPTH_C = PW'(1 << PKT_DEPTH_LOG2);
  localparam logic [PW-1:0] PKT_MAX_C   = PW'(PKT_MAX_BEATS);

  logic [BEAT_W-1:0]        pkt_q, pkt_peek;
  logic [PW-1:0]            pkt_count;
  logic                     pkt_full, pkt_empty;
  logic [META_W-1:0]        meta_q, meta_peek;
  logic [META_DEPTH_LOG2:0] meta_count;
  logic                     meta_full, meta_empty;

  logic          pkt_wr, pkt_drop, in_pkt, admit, tail_wr;
  logic [1:0]    in_tag;
  logic [PW-1:0] pkts_rdy;

  state_t state, state_nxt;
  logic   pkt_rd_en, meta_rd_en, start, emit, rest_q, rest_nxt;

  // Ingress: admission decided on head (or single) beat only.
  assign in_tag = i_pkt[TAG_HI:TAG_LO];
  assign admit  = (PKT_DEPTH_C - pkt_count) >= PKT_MAX_C;

  always_comb begin
    pkt_wr   = 1'b0;
    pkt_drop = 1'b0;
    if (i_pkt_valid) begin
      case (in_tag)
        TAG_HEAD, TAG_SINGLE: begin
          pkt_wr   = admit;
          pkt_drop = !admit;
        end
        TAG_TAIL: pkt_wr = in_pkt;
        default:  pkt_wr = in_pkt;
      endcase
    end
  end

  assign tail_wr = pkt_wr && tag_is_last(in_tag);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_pkt         <= 1'b0;
      o_pkt_drop_cnt <= '0;
      o_meta_ovf     <= 1'b0;
      pkts_rdy       <= '0;
    end else begin
      if (i_pkt_valid) begin
        if (in_tag == TAG_HEAD)      in_pkt <= admit;
        else if (tag_is_last(in_tag)) in_pkt <= 1'b0;
      end
      if (pkt_drop && o_pkt_drop_cnt != 16'hFFFF) o_pkt_drop_cnt <= o_pkt_drop_cnt + 16'd1;
      if (i_meta_valid && meta_full && !meta_rd_en) o_meta_ovf <= 1'b1;
      // Whole packets in the buffer; a packet may start only once its tail is in.
      case ({tail_wr, start})
        2'b10:   pkts_rdy <= pkts_rdy + 1'b1;
        2'b01:   pkts_rdy <= pkts_rdy - 1'b1;
        default: pkts_rdy <= pkts_rdy;
      endcase
    end
  end

  hypipe_sync_fifo #(.W(BEAT_W), .DEPTH_LOG2(PKT_DEPTH_LOG2)) u_pkt_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (pkt_wr),
    .wr_data   (i_pkt),
    .rd_en     (pkt_rd_en),
    .rd_data   (pkt_q),
    .peek_data (pkt_peek),
    .count     (pkt_count),
    .full      (pkt_full),
    .empty     (pkt_empty)
  );

  hypipe_sync_fifo #(.W(META_W), .DEPTH_LOG2(META_DEPTH_LOG2)) u_meta_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .wr_en     (i_meta_valid),
    .wr_data   (i_meta),
    .rd_en     (meta_rd_en),
    .rd_data   (meta_q),
    .peek_data (meta_peek),
    .count     (meta_count),
    .full      (meta_full),
    .empty     (meta_empty)
  );

  // IDLE pops the head beat together with its metadata; rest_q forces one idle cycle after a tail.
  always_comb begin
    state_nxt  = state;
    pkt_rd_en  = 1'b0;
    meta_rd_en = 1'b0;
    start      = 1'b0;
    emit       = 1'b0;
    rest_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rest_q && pkts_rdy != '0 && !meta_empty) begin
          start      = 1'b1;
          pkt_rd_en  = 1'b1;
          meta_rd_en = 1'b1;
          emit       = !meta_peek[DROP_BIT];
          if (tag_is_last(pkt_peek[TAG_HI:TAG_LO])) rest_nxt = 1'b1;
          else state_nxt = meta_peek[DROP_BIT] ? S_DROP : S_SEND;
        end
      end
      S_SEND, S_DROP: begin
        pkt_rd_en = 1'b1;
        emit      = (state == S_SEND);
        if (tag_is_last(pkt_peek[TAG_HI:TAG_LO])) begin
          state_nxt = S_IDLE;
          rest_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rest_q       <= 1'b0;
      o_data_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      rest_q       <= rest_nxt;
      o_data_valid <= emit;
    end
  end

  // pkt_q and meta_q only change on pops, so o_data holds between packets.
  always_comb begin
    o_data = pkt_q;
    if (tag_is_first(pkt_q[TAG_HI:TAG_LO]) && meta_q[REWRITE_BIT]) begin
      o_data[DMAC_HI:DMAC_LO] = meta_q[DMAC_LSB +: MAC_W];
`ifdef REPLACE_SRC_MAC_EN
      o_data[SMAC_HI:SMAC_LO] = pkt_q[DMAC_HI:DMAC_LO];
`endif
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pkt_full, pkt_empty, meta_count, meta_q, meta_peek, pkt_peek};

endmodule

// File: tb/tb_pkt_meta_merge_out.sv
// Scoreboard bench for pkt_meta_merge_out: directed packets/metadata, queued expectations.
module tb_pkt_meta_merge_out;

  logic         clk, rst;
  logic         i_pkt_valid, i_meta_valid;
  logic [133:0] i_pkt;
  logic [127:0] i_meta;
  logic         o_data_valid;
  logic [133:0] o_data;
  logic [15:0]  o_pkt_drop_cnt;
  logic         o_meta_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [133:0] exp_q[$];

  pkt_meta_merge_out dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pkt_valid    (i_pkt_valid),
    .i_pkt          (i_pkt),
    .i_meta_valid   (i_meta_valid),
    .i_meta         (i_meta),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .o_pkt_drop_cnt (o_pkt_drop_cnt),
    .o_meta_ovf     (o_meta_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [133:0] act, input logic [133:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [133:0] mk_beat(input int pid, input int i, input int n,
                                           input logic [47:0] dmac);
    logic [1:0]   tg;
    logic [127:0] d;
    if (n == 1)          tg = 2'b11;
    else if (i == 0)     tg = 2'b01;
    else if (i == n - 1) tg = 2'b10;
    else                 tg = 2'b00;
    if (i == 0) d = {dmac, 40'h0A0B0C0D0E, pid[7:0], 16'hC0DE, pid[15:0]};
    else        d = {pid[15:0], i[15:0], 96'h5A5A_0000_1111_2222_3333_4444};
    return {tg, i[3:0], d};
  endfunction

  function automatic logic [127:0] mk_meta(input logic drop, input logic rw, input logic [47:0] dmac);
    return {63'b0, drop, rw, 15'b0, dmac};
  endfunction

  // Reference transform: dst MAC rewrite on the first beat; optional src MAC copy.
  function automatic logic [133:0] xform(input logic [133:0] b, input logic [127:0] m);
    logic [133:0] r;
    r = b;
    if (b[132] && m[63]) begin
      r[127:80] = m[47:0];
`ifdef REPLACE_SRC_MAC_EN
      r[79:32] = b[127:80];
`endif
    end
    return r;
  endfunction

  task automatic push_exp(input int pid, input int n, input logic [47:0] dmac, input logic [127:0] m);
    if (!m[64])
      for (int i = 0; i < n; i++) exp_q.push_back(xform(mk_beat(pid, i, n, dmac), m));
  endtask

  task automatic send_pkt(input int pid, input int n, input logic [47:0] dmac);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_pkt_valid = 1'b1;
      i_pkt       = mk_beat(pid, i, n, dmac);
    end
    @(negedge clk);
    i_pkt_valid = 1'b0;
  endtask

  task automatic send_meta(input logic [127:0] m);
    @(negedge clk);
    i_meta_valid = 1'b1;
    i_meta       = m;
    @(negedge clk);
    i_meta_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every valid output beat must match the head of the expectation queue.
  initial begin
    logic [133:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_data_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got beat %h expected no output", o_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", o_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] m;
    logic [47:0]  smac_exp;
    logic [7:0]   kb;
    int           t;

    rst = 1'b1; i_pkt_valid = 1'b0; i_pkt = '0; i_meta_valid = 1'b0; i_meta = '0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {133'b0, o_data_valid}, '0);
    check("rst_data", o_data, '0);
    check("rst_drop_cnt", {118'b0, o_pkt_drop_cnt}, '0);
    check("rst_ovf", {133'b0, o_meta_ovf}, '0);

    // Test 1: 4-beat packet then rewrite meta; first output 2 cycles after meta.
    send_pkt(1, 4, 48'h001122334455);
    idle(3);
    m = mk_meta(1'b0, 1'b1, 48'hAABBCCDDEEFF);
    push_exp(1, 4, 48'h001122334455, m);
    @(negedge clk);
    i_meta_valid = 1'b1; i_meta = m;
    @(negedge clk);
    i_meta_valid = 1'b0;
    check("t1_lat_early", {133'b0, o_data_valid}, '0);
    @(negedge clk);
    check("t1_lat_first", {133'b0, o_data_valid}, 134'd1);
    check("t1_dmac", {86'b0, o_data[127:80]}, {86'b0, 48'hAABBCCDDEEFF});
`ifdef REPLACE_SRC_MAC_EN
    smac_exp = 48'h001122334455;
`else
    smac_exp = 48'h0A0B0C0D0E01;
`endif
    check("t1_smac", {86'b0, o_data[79:32]}, {86'b0, smac_exp});
    idle(10);
    check("t1_done", 134'(exp_q.size()), '0);

    // Test 2: meta 20 cycles ahead of a single-beat packet.
    m = mk_meta(1'b0, 1'b1, 48'h112233445566);
    send_meta(m);
    idle(20);
    push_exp(2, 1, 48'h665544332211, m);
    @(negedge clk);
    i_pkt_valid = 1'b1; i_pkt = mk_beat(2, 0, 1, 48'h665544332211);
    @(negedge clk);
    i_pkt_valid = 1'b0;
    check("t2_lat_early", {133'b0, o_data_valid}, '0);
    @(negedge clk);
    check("t2_lat_out", {133'b0, o_data_valid}, 134'd1);
    @(negedge clk);
    check("t2_one_beat", {133'b0, o_data_valid}, '0);

    // Test 3: first packet dropped by meta, second passed unmodified.
    send_pkt(3, 3, 48'h0000000000A3);
    send_pkt(4, 2, 48'h0000000000A4);
    push_exp(4, 2, 48'h0000000000A4, mk_meta(1'b0, 1'b0, 48'hFFFFFFFFFFFF));
    send_meta(mk_meta(1'b1, 1'b1, 48'h010101010101));
    send_meta(mk_meta(1'b0, 1'b0, 48'hFFFFFFFFFFFF));
    idle(20);
    check("t3_drop_cnt", {118'b0, o_pkt_drop_cnt}, '0);
    check("t3_done", 134'(exp_q.size()), '0);

    // Test 4: 400 beats buffered -> next packet refused at ingress.
    for (int k = 0; k < 4; k++) send_pkt(10 + k, 100, 48'h0000000000B0);
    send_pkt(14, 3, 48'h0000000000B4);
    idle(2);
    check("t4_drop_cnt", {118'b0, o_pkt_drop_cnt}, 134'd1);
    for (int k = 0; k < 4; k++) send_meta(mk_meta(1'b1, 1'b0, 48'h0));
    idle(450);
    m = mk_meta(1'b0, 1'b1, 48'hCAFEBABE0015);
    push_exp(15, 3, 48'h0000000000B5, m);
    send_pkt(15, 3, 48'h0000000000B5);
    send_meta(m);
    idle(20);
    check("t4_drop_cnt_after", {118'b0, o_pkt_drop_cnt}, 134'd1);
    check("t4_done", 134'(exp_q.size()), '0);

    // Test 5: 17 metas overflow the 16-entry buffer; 16 packets then drain.
    for (int k = 0; k < 17; k++) begin
      kb = k[7:0];
      @(negedge clk);
      i_meta_valid = 1'b1;
      i_meta       = mk_meta(1'b0, 1'b1, {40'hFEEDFACE00, kb});
    end
    @(negedge clk);
    i_meta_valid = 1'b0;
    check("t5_ovf", {133'b0, o_meta_ovf}, 134'd1);
    for (int k = 0; k < 16; k++) begin
      kb = k[7:0];
      push_exp(20 + k, 2, 48'h0000000000C0, mk_meta(1'b0, 1'b1, {40'hFEEDFACE00, kb}));
      send_pkt(20 + k, 2, 48'h0000000000C0);
    end
    idle(60);
    check("t5_done", 134'(exp_q.size()), '0);
    check("t5_ovf_sticky", {133'b0, o_meta_ovf}, 134'd1);

    // Reset asserted in the middle of a SEND.
    m = mk_meta(1'b0, 1'b0, 48'h0);
    push_exp(40, 20, 48'h0000000000D0, m);
    send_meta(m);
    send_pkt(40, 20, 48'h0000000000D0);
    t = 0;
    while (!o_data_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_wait_timeout", {133'b0, (t >= 100)}, '0);
    idle(3);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_mid_valid", {133'b0, o_data_valid}, '0);
    check("rst_mid_drop_cnt", {118'b0, o_pkt_drop_cnt}, '0);
    check("rst_mid_ovf", {133'b0, o_meta_ovf}, '0);
    @(negedge clk);
    rst = 1'b0;
    idle(40);

    m = mk_meta(1'b0, 1'b1, 48'h123456789ABC);
    push_exp(50, 1, 48'h0000000000E0, m);
    send_pkt(50, 1, 48'h0000000000E0);
    send_meta(m);
    idle(10);
    check("sb_leftover", 134'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
